// File: rtl/mp_mem_ctrl_pkg.sv
// Shared definitions for the self-clearing memory arrays: clear-sequencer
// state encoding and the counter-width helper.
package mp_mem_ctrl_pkg;

    // Clear sequencer states: walking the array, then open for user traffic.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } clr_state_e;

    // Bits needed to index 'value' words; never less than 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mp_mem_ctrl_clear_seq.sv
// Clear sequencer: after reset, issues one INIT write per clock to
// addresses 0..N_ELEMENTS-1, then raises ready and stays there until the
// next reset. Lets the array itself go without a reset net.
module mp_mem_ctrl_clear_seq
    import mp_mem_ctrl_pkg::*;
#(
    parameter int N_ELEMENTS = 128,
    parameter int CNT_W      = clog2(N_ELEMENTS)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             clr_we,
    output logic [CNT_W-1:0] clr_addr,
    output logic             ready,
    output clr_state_e       state
);

    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(N_ELEMENTS - 1);

    clr_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and counter register; reset restarts the walk from address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: step the counter while clearing, leave on the last word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        unique case (state_q)
            ST_CLEAR: begin
                // No array write may happen on an edge where reset is held.
                clr_we = !rst;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
        endcase
    end

    assign clr_addr = cnt_q;
    assign ready    = (state_q == ST_READY);
    assign state    = state_q;

endmodule

// File: rtl/mp_mem_ctrl.sv
// Multi-port register/memory array with a self-clearing reset sequencer.
// N_RD read ports, N_WR write ports (highest index wins on collisions),
// combinational or registered read with write-to-read bypass, and a
// registered out-of-range flag.
module mp_mem_ctrl
    import mp_mem_ctrl_pkg::*;
#(
    parameter int                    N_ELEMENTS = 128,
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    N_RD       = 2,
    parameter int                    N_WR       = 1,
    parameter int                    READ_LAT   = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_RD*ADDR_WIDTH-1:0]   r_addr,
    output logic [N_RD*DATA_WIDTH-1:0]   r_data,
    input  logic [N_WR*ADDR_WIDTH-1:0]   w_addr,
    input  logic [N_WR*DATA_WIDTH-1:0]   w_data,
    input  logic [N_WR-1:0]              w_en,
    output logic                         ready,
    output logic                         addr_err
);

    localparam int                    CNT_W  = clog2(N_ELEMENTS);
    localparam logic [ADDR_WIDTH-1:0] N_ADDR = ADDR_WIDTH'(N_ELEMENTS);

    logic             clr_we;
    logic [CNT_W-1:0] clr_addr;
    clr_state_e       clr_state;
    logic             wr_ok;

    logic [DATA_WIDTH-1:0] mem_q [N_ELEMENTS];
    logic [DATA_WIDTH-1:0] mem_d [N_ELEMENTS];

    logic [N_RD-1:0]       r_oob;
    logic [DATA_WIDTH-1:0] rd_mem [N_RD];
    logic                  err_q, err_d;

    mp_mem_ctrl_clear_seq #(
        .N_ELEMENTS (N_ELEMENTS),
        .CNT_W      (CNT_W)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .ready    (ready),
        .state    (clr_state)
    );

    // User writes only land once the walk is done and reset is released.
    assign wr_ok = (clr_state == ST_READY) && !rst;

    // Per-element write mux: clear path first, then user ports in ascending
    // order so the highest-index port overrides the others.
    always_comb begin
        for (int e = 0; e < N_ELEMENTS; e++) begin
            mem_d[e] = mem_q[e];
            if (clr_we && (clr_addr == CNT_W'(e))) begin
                mem_d[e] = INIT_VALUE;
            end else if (wr_ok) begin
                for (int j = 0; j < N_WR; j++) begin
                    if (w_en[j] && (w_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(e))) begin
                        mem_d[e] = w_data[j*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    // Array storage; deliberately unreset, the clear sequencer initialises it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Raw array read per port with full-width range check; out of range reads 0.
    always_comb begin
        for (int k = 0; k < N_RD; k++) begin
            r_oob[k]  = (r_addr[k*ADDR_WIDTH +: ADDR_WIDTH] >= N_ADDR);
            rd_mem[k] = r_oob[k] ? '0 : mem_q[r_addr[k*ADDR_WIDTH +: CNT_W]];
        end
    end

    // Range violation of this cycle, any read port or any enabled write port.
    always_comb begin
        err_d = |r_oob;
        for (int j = 0; j < N_WR; j++) begin
            if (w_en[j] && (w_addr[j*ADDR_WIDTH +: ADDR_WIDTH] >= N_ADDR)) begin
                err_d = 1'b1;
            end
        end
    end

    // Registered range-error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign addr_err = err_q;

    if (READ_LAT == 1) begin : g_reg_read
        logic [N_WR-1:0]           w_live;
        logic [N_RD*DATA_WIDTH-1:0] rdata_q, rdata_d;

        // Registered read: forward a winning same-edge write so the captured
        // word matches what the array holds after this edge.
        always_comb begin
            for (int j = 0; j < N_WR; j++) begin
                w_live[j] = wr_ok && w_en[j] &&
                            (w_addr[j*ADDR_WIDTH +: ADDR_WIDTH] < N_ADDR);
            end
            rdata_d = '0;
            for (int k = 0; k < N_RD; k++) begin
                if (ready) begin
                    rdata_d[k*DATA_WIDTH +: DATA_WIDTH] = rd_mem[k];
                    for (int j = 0; j < N_WR; j++) begin
                        if (w_live[j] && (w_addr[j*ADDR_WIDTH +: ADDR_WIDTH] ==
                                          r_addr[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
                            rdata_d[k*DATA_WIDTH +: DATA_WIDTH] = w_data[j*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                end
            end
        end

        // Read data register.
        always_ff @(posedge clk) begin
            if (rst) begin
                rdata_q <= '0;
            end else begin
                rdata_q <= rdata_d;
            end
        end

        assign r_data = ready ? rdata_q : '0;
    end else begin : g_comb_read
        // Combinational read, held at zero until the array is cleared.
        always_comb begin
            r_data = '0;
            for (int k = 0; k < N_RD; k++) begin
                if (ready) begin
                    r_data[k*DATA_WIDTH +: DATA_WIDTH] = rd_mem[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_mp_mem_ctrl.sv
// Bench for mp_mem_ctrl: one combinational-read and one registered-read
// instance share random stimulus and are compared every cycle against a
// behavioural model, with directed scenarios pinned by literal values.
module tb_mp_mem_ctrl;

    localparam int N  = 128;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int NR = 2;
    localparam int NW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NR*AW-1:0] r_addr;
    logic [NW*AW-1:0] w_addr;
    logic [NW*DW-1:0] w_data;
    logic [NW-1:0]    w_en;
    logic [NR*DW-1:0] r_data0, r_data1;
    logic             ready0, ready1, err0, err1;

    int n_total = 0;
    int n_pass  = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    mp_mem_ctrl #(
        .N_ELEMENTS (N), .ADDR_WIDTH (AW), .DATA_WIDTH (DW),
        .N_RD (NR), .N_WR (NW), .READ_LAT (0), .INIT_VALUE ('0)
    ) u_comb (
        .clk (clk), .rst (rst), .r_addr (r_addr), .r_data (r_data0),
        .w_addr (w_addr), .w_data (w_data), .w_en (w_en),
        .ready (ready0), .addr_err (err0)
    );

    mp_mem_ctrl #(
        .N_ELEMENTS (N), .ADDR_WIDTH (AW), .DATA_WIDTH (DW),
        .N_RD (NR), .N_WR (NW), .READ_LAT (1), .INIT_VALUE ('0)
    ) u_reg (
        .clk (clk), .rst (rst), .r_addr (r_addr), .r_data (r_data1),
        .w_addr (w_addr), .w_data (w_data), .w_en (w_en),
        .ready (ready1), .addr_err (err1)
    );

    // ---------------- checking helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [AW-1:0] ra(input int k);
        return r_addr[k*AW +: AW];
    endfunction
    function automatic logic [AW-1:0] wa(input int j);
        return w_addr[j*AW +: AW];
    endfunction
    function automatic logic [DW-1:0] wd(input int j);
        return w_data[j*DW +: DW];
    endfunction

    // ---------------- behavioural model ----------------
    // Ready = N clear edges seen since reset dropped; a registered read
    // returns the word the array holds after that edge's writes.
    logic [DW-1:0] m_mem [N];
    logic [DW-1:0] m_lat1 [NR];
    int            clr_done = 0;
    bit            m_ready  = 0;
    bit            m_err    = 0;
    bit            m_valid  = 0;

    always @(posedge clk) begin
        bit any_oob;
        if (rst) begin
            m_valid  = 1;
            clr_done = 0;
            m_ready  = 0;
            m_err    = 0;
            for (int k = 0; k < NR; k++) m_lat1[k] = '0;
        end else begin
            any_oob = 0;
            for (int k = 0; k < NR; k++) if (ra(k) >= N) any_oob = 1;
            for (int j = 0; j < NW; j++) if (w_en[j] && wa(j) >= N) any_oob = 1;
            if (!m_ready) begin
                m_mem[clr_done] = '0;
                clr_done++;
                if (clr_done == N) m_ready = 1;
                for (int k = 0; k < NR; k++) m_lat1[k] = '0;
            end else begin
                for (int j = 0; j < NW; j++)
                    if (w_en[j] && wa(j) < N) m_mem[wa(j)] = wd(j);
                for (int k = 0; k < NR; k++)
                    m_lat1[k] = (ra(k) < N) ? m_mem[ra(k)] : '0;
            end
            m_err = any_oob;
        end
    end

    // ---------------- scoreboard compare (every cycle) ----------------
    always @(negedge clk) begin
        logic [DW-1:0] exp0;
        logic [DW-1:0] exp1;
        if (m_valid) begin
            chk("ready_comb", ready0, m_ready);
            chk("ready_reg", ready1, m_ready);
            chk("err_comb", err0, m_err);
            chk("err_reg", err1, m_err);
            for (int k = 0; k < NR; k++) begin
                exp0 = (m_ready && ra(k) < N) ? m_mem[ra(k)] : '0;
                exp1 = m_ready ? m_lat1[k] : '0;
                chk($sformatf("rdata_comb[%0d]", k), r_data0[k*DW +: DW], exp0);
                chk($sformatf("rdata_reg[%0d]", k), r_data1[k*DW +: DW], exp1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        r_addr = '0;
        w_addr = '0;
        w_data = '0;
        w_en   = '0;
    endtask

    // Mostly a small window (collisions, bypass hits), sometimes out of
    // range, sometimes high bits set so a truncating compare would alias.
    task automatic rnd_addr(output logic [AW-1:0] a);
        case ($urandom_range(0, 9))
            0:       a = AW'($urandom_range(128, 255));
            1:       a = 16'hFF80 | AW'($urandom_range(0, 15));
            default: a = AW'($urandom_range(0, 15));
        endcase
    endtask

    task automatic drive_random();
        logic [AW-1:0] a;
        for (int k = 0; k < NR; k++) begin
            rnd_addr(a);
            r_addr[k*AW +: AW] = a;
        end
        for (int j = 0; j < NW; j++) begin
            rnd_addr(a);
            w_addr[j*AW +: AW] = a;
            w_data[j*DW +: DW] = DW'($urandom);
        end
        w_en = NW'($urandom_range(0, 3));
    endtask

    // Called one step after the last reset edge; counts edges until ready.
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        forever begin
            drive_random();
            @(negedge clk);
            if (ready0 || n >= 400) break;
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, n, 128);
        #1;
        idle();
        next_cycle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle();
        repeat (3) next_cycle();
        @(negedge clk);
        chk("reset_ready", ready0, 1'b0);
        chk("reset_err", err0, 1'b0);
        chk("reset_rdata_reg", r_data1, 32'h0);
        next_cycle();

        rst = 1'b0;
        wait_ready("clear_edges");

        repeat (300) begin
            drive_random();
            next_cycle();
        end

        // Restart in the middle of a clear; writes during the walk are lost.
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        repeat (50) begin
            drive_random();
            next_cycle();
        end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        wait_ready("restart_edges");

        for (int a = 0; a < N; a++) begin
            r_addr = {AW'(N - 1 - a), AW'(a)};
            @(negedge clk);
            chk("cleared_word", r_data0, 32'h0);
            next_cycle();
        end

        // Write collision: port 1 wins.
        w_addr = {16'd5, 16'd5};
        w_data = {16'h5555, 16'hAAAA};
        w_en   = 2'b11;
        r_addr = {16'd5, 16'd5};
        next_cycle();
        w_en = 2'b00;
        @(negedge clk);
        chk("collision_comb", r_data0[DW-1:0], 16'h5555);
        chk("collision_reg", r_data1[DW-1:0], 16'h5555);
        next_cycle();

        // Old value at address 7, then the same-edge write/read pair.
        idle();
        w_addr[AW-1:0] = 16'd7;
        w_data[DW-1:0] = 16'h0BAD;
        w_en           = 2'b01;
        next_cycle();
        w_data[DW-1:0] = 16'h1234;
        r_addr[AW-1:0] = 16'd7;
        @(negedge clk);
        chk("same_cycle_old_comb", r_data0[DW-1:0], 16'h0BAD);
        next_cycle();
        w_en = 2'b00;
        @(negedge clk);
        chk("next_cycle_new_comb", r_data0[DW-1:0], 16'h1234);
        chk("bypass_reg", r_data1[DW-1:0], 16'h1234);
        next_cycle();

        // Out-of-range write and read.
        idle();
        w_addr[AW-1:0] = 16'd200;
        w_data[DW-1:0] = 16'hDEAD;
        w_en           = 2'b01;
        next_cycle();
        idle();
        @(negedge clk);
        chk("oob_write_err", err0, 1'b1);
        chk("oob_write_err_reg", err1, 1'b1);
        next_cycle();
        r_addr[AW-1:0] = 16'd200;
        @(negedge clk);
        chk("oob_err_one_cycle", err0, 1'b0);
        chk("oob_read_zero", r_data0[DW-1:0], 16'h0);
        next_cycle();
        r_addr[AW-1:0] = 16'd72;
        @(negedge clk);
        chk("oob_read_err", err0, 1'b1);
        chk("oob_no_alias", r_data0[DW-1:0], 16'h0);
        next_cycle();

        repeat (300) begin
            drive_random();
            next_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Watchdog so a stuck run still terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
